hello_rotate_register: RTL
==========================

HELLO_ROTATE_REGISTER -- requirements
Module: hello_rotate_register

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, in the ports Clock and Reset.
REQ-002 Parameter TICK_DIV, default 25000000, SHALL set the Clock cycles per rotation step (legal range >= 1).
REQ-003 Clock  in  1  system clock; all state changes on posedge.
REQ-004 Reset  in  1  asynchronous active-high clear.
REQ-005 Shift  in  1  1 = rotate mode; 0 = load mode.
REQ-006 InChar  in  3  character code to load: 0 blank, 1 H, 2 E, 3 L, 4 O; codes 5-7 display as blank.
REQ-007 InValid  in  1  load strobe; InChar is captured on a posedge where InValid=1 and Shift=0.
REQ-008 HEX7..HEX0  out  7 each  active-low segments {g,f,e,d,c,b,a}; HEX7 is the leftmost digit.
REQ-009 Tick  out  1  one-cycle pulse in the cycle after each rotation step.
REQ-010 RotCount  out  3  rotation steps taken, modulo 8.

Function
REQ-011 The block SHALL hold an 8-entry by 3-bit character register Reg[7:0]; Reg[i] drives HEXi through the decoder.
REQ-012 Decode SHALL be: blank 7'h7F, H 7'h09, E 7'h06, L 7'h47, O 7'h40; HEX outputs SHALL be combinational from Reg.
REQ-013 Load (Shift=0, InValid=1): Reg[i] <= Reg[i-1] for i=7..1 and Reg[0] <= InChar, in one cycle.
REQ-014 Shift=0 with InValid=0 SHALL hold Reg.
REQ-015 In rotate mode, the prescaler SHALL count 0..TICK_DIV-1; at terminal count it SHALL wrap to 0 and do one left rotate: Reg[i] <= Reg[i-1], Reg[0] <= Reg[7].
REQ-016 Each rotate SHALL increment RotCount (7 wraps to 0) and assert Tick for exactly the following cycle.
REQ-017 The first rotate SHALL occur TICK_DIV cycles after the first posedge at which Shift=1.
REQ-018 When Shift=1, InValid SHALL be ignored (rotate has priority).
REQ-019 When Shift=0, the prescaler SHALL clear to 0; Reg and RotCount SHALL hold; Tick SHALL be 0.
REQ-020 With TICK_DIV=1, a rotate SHALL occur on every cycle with Shift=1.
REQ-021 The prescaler width SHALL be $clog2(TICK_DIV), minimum 1 bit; there SHALL be no overflow at any legal TICK_DIV.

Reset
REQ-022 Reset=1 SHALL, without a clock edge, set all Reg to blank, the prescaler to 0, RotCount to 0 and Tick to 0; HEX7..HEX0 SHALL then read 7'h7F.
REQ-023 Reset asserted during rotate or load SHALL abort the operation; after release, the block SHALL resume from the cleared state.

Configuration
REQ-024 With ROTATE_DIR_EN defined, an input Dir (1 bit) SHALL exist; Dir=1 SHALL select right rotation (Reg[i] <= Reg[i+1], Reg[7] <= Reg[0]), and Dir=0 SHALL select left rotation.
REQ-025 Without ROTATE_DIR_EN, the Dir port SHALL be absent and rotation SHALL always be left; load direction is left in both builds.

Structure
REQ-026 Package hello_disp_pkg SHALL hold the character code constants, the segment patterns and NUM_DIGITS=8.
REQ-027 Sub-module char_to_seg7 (3-bit code to 7-bit active-low segments, combinational) SHALL be instantiated 8 times.

Verification (TICK_DIV=4 unless stated)
REQ-028 Reset pulse mid-run -> all HEX=7'h7F, RotCount=0 and Tick=0, immediately and asynchronously.
REQ-029 Load H,E,L,L,O,0,0,0 with Shift=0 -> HEX7..HEX0 = 09,06,47,47,40,7F,7F,7F; RotCount=0.
REQ-030 After the REQ-029 load, set Shift=1 for 4 cycles -> one rotate to HEX7..HEX0 = 06,47,47,40,7F,7F,7F,09; Tick pulses once; RotCount=1.
REQ-031 Shift=1 for 32 cycles -> 8 rotates, the display returns to HELLO___, and RotCount=0.
REQ-032 Shift=1 with InValid=1 and InChar=1 -> no load occurs, only rotates; drop Shift at count 2 -> Reg holds and the next rotate occurs 4 cycles after Shift re-asserts.
REQ-033 ROTATE_DIR_EN build with Dir=1 after the REQ-029 load, 4 cycles -> HEX7..HEX0 = 7F,09,06,47,47,40,7F,7F.

Source files
------------

// File: rtl/hello_disp_pkg.sv
// Shared constants for the HELLO rotating display: character codes,
// active-low segment patterns {g,f,e,d,c,b,a} and the digit count.
package hello_disp_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [2:0] CH_BLANK = 3'd0;
    localparam logic [2:0] CH_H     = 3'd1;
    localparam logic [2:0] CH_E     = 3'd2;
    localparam logic [2:0] CH_L     = 3'd3;
    localparam logic [2:0] CH_O     = 3'd4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_H     = 7'h09;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_O     = 7'h40;

    // Codes 5..7 are not characters and fall through to blank.
    function automatic logic [6:0] code_to_seg(input logic [2:0] code);
        case (code)
            CH_H:    return SEG_H;
            CH_E:    return SEG_E;
            CH_L:    return SEG_L;
            CH_O:    return SEG_O;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/hello_rotate_register_if.sv
// Control and display bundle for hello_rotate_register.
// Optional macro ROTATE_DIR_EN adds the Dir (rotation direction) signal.
interface hello_rotate_register_if;

    logic       Shift;
    logic       InValid;
    logic [2:0] InChar;
`ifdef ROTATE_DIR_EN
    logic       Dir;
`endif
    logic [6:0] HEX7;
    logic [6:0] HEX6;
    logic [6:0] HEX5;
    logic [6:0] HEX4;
    logic [6:0] HEX3;
    logic [6:0] HEX2;
    logic [6:0] HEX1;
    logic [6:0] HEX0;
    logic       Tick;
    logic [2:0] RotCount;

    modport master (
`ifdef ROTATE_DIR_EN
        output Dir,
`endif
        output Shift, InValid, InChar,
        input  HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0,
        input  Tick, RotCount
    );

    modport slave (
`ifdef ROTATE_DIR_EN
        input  Dir,
`endif
        input  Shift, InValid, InChar,
        output HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0,
        output Tick, RotCount
    );

endinterface

// File: rtl/char_to_seg7.sv
// Combinational 3-bit character code to active-low 7-segment decoder.
module char_to_seg7
    import hello_disp_pkg::*;
(
    input  logic [2:0] code,
    output logic [6:0] seg
);

    // Pure lookup; unused codes decode to blank.
    always_comb begin
        seg = code_to_seg(code);
    end

endmodule

// File: rtl/hello_rotate_register.sv
// Eight-digit character register that loads by shifting in from the right
// and, in rotate mode, rotates once every TICK_DIV clocks.
// Optional macro ROTATE_DIR_EN enables the Dir input (1 = rotate right).
module hello_rotate_register
    import hello_disp_pkg::*;
#(
    parameter int TICK_DIV = 25000000
) (
    input  logic                    Clock,
    input  logic                    Reset,
    hello_rotate_register_if.slave  bus
);

    // At least one prescaler bit so TICK_DIV=1 still has a legal counter.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_reg;
    logic [2:0]    char_reg  [NUM_DIGITS];
    logic [2:0]    char_next [NUM_DIGITS];
    logic [2:0]    rot_count_reg;
    logic          tick_reg;
    logic          rotate_now;
    logic          dir_right;
    logic [6:0]    seg [NUM_DIGITS];

`ifdef ROTATE_DIR_EN
    assign dir_right = bus.Dir;
`else
    assign dir_right = 1'b0;
`endif

    // A rotate fires on the clock where the prescaler sits at terminal count.
    assign rotate_now = bus.Shift && (presc_reg == TERM);

    // Per-digit next value: rotate wins over load; load shifts toward HEX7.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            localparam int LEFT_SRC  = (gi + NUM_DIGITS - 1) % NUM_DIGITS;
            localparam int RIGHT_SRC = (gi + 1) % NUM_DIGITS;
            logic [2:0] rot_src;
            logic [2:0] load_src;

            assign rot_src = dir_right ? char_reg[RIGHT_SRC] : char_reg[LEFT_SRC];

            if (gi == 0) begin : g_load_in
                assign load_src = bus.InChar;
            end else begin : g_load_shift
                assign load_src = char_reg[gi-1];
            end

            assign char_next[gi] = bus.Shift
                                 ? (rotate_now  ? rot_src  : char_reg[gi])
                                 : (bus.InValid ? load_src : char_reg[gi]);

            char_to_seg7 u_dec (
                .code (char_reg[gi]),
                .seg  (seg[gi])
            );
        end
    endgenerate

    // Prescaler runs only in rotate mode and restarts whenever Shift drops.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            presc_reg <= '0;
        end else if (!bus.Shift || rotate_now) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PW'(1);
        end
    end

    // Character storage; reset clears every digit to blank.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                char_reg[i] <= CH_BLANK;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                char_reg[i] <= char_next[i];
            end
        end
    end

    // Rotation counter and the one-cycle Tick that follows each rotate.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rot_count_reg <= 3'd0;
            tick_reg      <= 1'b0;
        end else begin
            tick_reg <= rotate_now;
            if (rotate_now) begin
                rot_count_reg <= rot_count_reg + 3'd1;
            end
        end
    end

    assign bus.HEX0     = seg[0];
    assign bus.HEX1     = seg[1];
    assign bus.HEX2     = seg[2];
    assign bus.HEX3     = seg[3];
    assign bus.HEX4     = seg[4];
    assign bus.HEX5     = seg[5];
    assign bus.HEX6     = seg[6];
    assign bus.HEX7     = seg[7];
    assign bus.Tick     = tick_reg;
    assign bus.RotCount = rot_count_reg;

endmodule
